// File: rtl/seg_pipe_adder_if.sv
// Operand/result bus for seg_pipe_adder.
// Handshake: a beat transfers on a rising edge where its valid and ready are both 1;
// in_ready may depend combinationally on out_valid/out_ready, never on in_valid.
interface seg_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/seg_pipe_adder.sv
// Segment-pipelined add/subtract: one SEG-bit slice per stage, carry registered between
// stages, operands skewed in and sum slices deskewed out so each result emerges aligned.
module seg_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input logic             clk,
  input logic             rst,
  seg_pipe_adder_if.slave bus
);
  localparam int STAGES = WIDTH / SEG;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  always_comb begin
    b_eff = bus.sub ? ~bus.b : bus.b;
    c0    = bus.sub ? ~bus.cin : bus.cin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * SEG;

    logic [SEG-1:0]  a_s;
    logic [SEG-1:0]  b_s;
    logic            c_in;
    logic            v_in;
    logic [SEG:0]    slice;
    logic [DONE-1:0] sum_d;
    logic [DONE-1:0] sum_q;
    logic            carry_d;
    logic            carry_q;
    logic            valid_d;
    logic            valid_q;

    if (k == 0) begin : g_src
      assign a_s   = bus.a[SEG-1:0];
      assign b_s   = b_eff[SEG-1:0];
      assign c_in  = c0;
      assign v_in  = bus.in_valid;
      assign sum_d = slice[SEG-1:0];
    end else begin : g_src
      // Low bits of the skew register are exactly this stage's slice.
      assign a_s   = g_stage[k-1].g_skew.rem_a_q[SEG-1:0];
      assign b_s   = g_stage[k-1].g_skew.rem_b_q[SEG-1:0];
      assign c_in  = g_stage[k-1].carry_q;
      assign v_in  = g_stage[k-1].valid_q;
      assign sum_d = {slice[SEG-1:0], g_stage[k-1].sum_q};
    end

    always_comb begin
      slice   = {1'b0, a_s} + {1'b0, b_s} + {{SEG{1'b0}}, c_in};
      carry_d = slice[SEG];
      valid_d = v_in;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (en) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      localparam int RW = WIDTH - DONE;
      logic [RW-1:0] rem_a_d;
      logic [RW-1:0] rem_a_q;
      logic [RW-1:0] rem_b_d;
      logic [RW-1:0] rem_b_q;

      if (k == 0) begin : g_rem
        assign rem_a_d = bus.a[WIDTH-1:SEG];
        assign rem_b_d = b_eff[WIDTH-1:SEG];
      end else begin : g_rem
        assign rem_a_d = g_stage[k-1].g_skew.rem_a_q[WIDTH-k*SEG-1:SEG];
        assign rem_b_d = g_stage[k-1].g_skew.rem_b_q[WIDTH-k*SEG-1:SEG];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rem_a_q <= '0;
          rem_b_q <= '0;
        end else if (en) begin
          rem_a_q <= rem_a_d;
          rem_b_q <= rem_b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
      always_comb begin
        ovf_d = (a_s[SEG-1] ^ b_s[SEG-1] ^ slice[SEG-1]) ^ slice[SEG];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  always_comb begin
    en = !g_stage[STAGES-1].valid_q | bus.out_ready;
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = g_stage[STAGES-1].valid_q;
  assign bus.sum       = g_stage[STAGES-1].sum_q;
  assign bus.cout      = g_stage[STAGES-1].carry_q;
  assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_seg_pipe_adder.sv
// Bench for seg_pipe_adder: three instances (16/4, 16/16, 32/8) share one stimulus stream,
// each with its own expected queue; directed table plus streaming, random and reset sequences.
module tb_seg_pipe_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        cin;
  logic        sub;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;

  int total = 0;
  int bad   = 0;
  int acc0  = 0;

  logic [33:0] exp_q[3][$];
  bit          held[3];
  logic [34:0] held_val[3];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  seg_pipe_adder_if #(.WIDTH(16)) if0 ();
  seg_pipe_adder_if #(.WIDTH(16)) if1 ();
  seg_pipe_adder_if #(.WIDTH(32)) if2 ();

  assign if0.in_valid  = in_valid;
  assign if0.a         = a[15:0];
  assign if0.b         = b[15:0];
  assign if0.cin       = cin;
  assign if0.sub       = sub;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.a         = a[15:0];
  assign if1.b         = b[15:0];
  assign if1.cin       = cin;
  assign if1.sub       = sub;
  assign if1.out_ready = out_ready;
  assign if2.in_valid  = in_valid;
  assign if2.a         = a;
  assign if2.b         = b;
  assign if2.cin       = cin;
  assign if2.sub       = sub;
  assign if2.out_ready = out_ready;

  seg_pipe_adder #(.WIDTH(16), .SEG(4))  u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  seg_pipe_adder #(.WIDTH(16), .SEG(16)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  seg_pipe_adder #(.WIDTH(32), .SEG(8))  u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  function automatic void check(string name, int i, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d act=%0h exp=%0h", name, i, act, exp);
    end
  endfunction

  // Reference: {ovf, cout, sum}; overflow from operand/result signs.
  function automatic logic [33:0] model(logic [31:0] a_i, logic [31:0] b_i, logic c_i,
                                        logic s_i, int w);
    logic [31:0] mask;
    logic [31:0] am;
    logic [31:0] bb;
    logic [32:0] full;
    logic [31:0] s;
    logic        co;
    logic        ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    am   = a_i & mask;
    bb   = (s_i ? ~b_i : b_i) & mask;
    full = {1'b0, am} + {1'b0, bb} + {32'h0, (s_i ? ~c_i : c_i)};
    s    = full[31:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
    return {ov, co, s};
  endfunction

  function automatic void chk(int i, int w, logic ov, logic ir, logic [31:0] s,
                              logic c, logic o);
    logic [34:0] got;
    logic [33:0] e;
    got = {ov, o, c, s};
    if (rst) begin
      exp_q[i].delete();
      held[i] = 1'b0;
    end else begin
      check("in_ready", i, 64'(ir), 64'(!ov | out_ready));
      if (held[i]) check("hold", i, 64'(got), 64'(held_val[i]));
      if (in_valid && ir) begin
        exp_q[i].push_back(model(a, b, cin, sub, w));
        if (i == 0) acc0++;
      end
      if (ov && out_ready) begin
        if (exp_q[i].size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out dut%0d act=%0h exp=none", i, got[33:0]);
        end else begin
          e = exp_q[i].pop_front();
          check("result", i, 64'(got[33:0]), 64'(e));
        end
      end
      held[i]     = ov && !out_ready;
      held_val[i] = got;
    end
  endfunction

  task automatic step();
    #2;
    chk(0, 16, if0.out_valid, if0.in_ready, 32'(if0.sum), if0.cout, if0.ovf);
    chk(1, 16, if1.out_valid, if1.in_ready, 32'(if1.sum), if1.cout, if1.ovf);
    chk(2, 32, if2.out_valid, if2.in_ready, if2.sum, if2.cout, if2.ovf);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) > 0; t++)
      step();
    step();
  endtask

  task automatic rand_ops();
    a   = $urandom;
    b   = $urandom;
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int          first[3];
    logic [17:0] got0;
    int          gaps[3];

    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[3]  = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    vecs[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[8]  = '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[9]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[10] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[11] = '{16'h8000, 16'h0000, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    // Reset, with a beat offered that must not be taken.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 32'h0000_1234; b = 32'h0000_1111; cin = 1'b0; sub = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();
    check("rst_out_valid", 0, 64'(if0.out_valid), 64'(0));
    check("rst_sum", 0, 64'(if0.sum), 64'(0));
    check("rst_cout", 0, 64'(if0.cout), 64'(0));
    check("rst_ovf", 0, 64'(if0.ovf), 64'(0));
    check("rst_out_valid", 1, 64'(if1.out_valid), 64'(0));
    check("rst_out_valid", 2, 64'(if2.out_valid), 64'(0));
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", 0, 64'(if0.in_ready), 64'(1));
    check("rst_in_ready", 2, 64'(if2.in_ready), 64'(1));
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 5; t++) step();

    // Directed table with latency from an empty pipe.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      a   = {16'h0, vecs[i].a};
      b   = {16'h0, vecs[i].b};
      cin = vecs[i].cin;
      sub = vecs[i].sub;
      step();
      in_valid = 1'b0;
      first = '{0, 0, 0};
      got0  = '0;
      for (int c = 1; c <= 6; c++) begin
        if (first[0] == 0 && if0.out_valid) begin
          first[0] = c;
          got0 = {if0.ovf, if0.cout, if0.sum};
        end
        if (first[1] == 0 && if1.out_valid) first[1] = c;
        if (first[2] == 0 && if2.out_valid) first[2] = c;
        step();
      end
      check("vec_sum", i, 64'(got0[15:0]), 64'(vecs[i].sum));
      check("vec_cout", i, 64'(got0[16]), 64'(vecs[i].cout));
      check("vec_ovf", i, 64'(got0[17]), 64'(vecs[i].ovf));
      check("latency", 0, 64'(first[0]), 64'(4));
      check("latency", 1, 64'(first[1]), 64'(1));
      check("latency", 2, 64'(first[2]), 64'(4));
    end

    // Full-throughput stream: no gaps after fill.
    drain();
    gaps = '{0, 0, 0};
    in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (t >= 4 && !if0.out_valid) gaps[0]++;
      if (t >= 1 && !if1.out_valid) gaps[1]++;
      if (t >= 4 && !if2.out_valid) gaps[2]++;
      rand_ops();
      step();
    end
    for (int i = 0; i < 3; i++) check("stream_gaps", i, 64'(gaps[i]), 64'(0));
    drain();

    // Random valid/ready, until 1000 beats enter the 16/4 instance.
    acc0 = 0;
    for (int t = 0; t < 8000 && acc0 < 1000; t++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      rand_ops();
      step();
    end
    check("rand_beats", 0, 64'(acc0 >= 1000), 64'(1));
    drain();

    // Reset with three beats in flight; a beat is also offered during reset.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      rand_ops();
      step();
    end
    rst = 1'b1;
    rand_ops();
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_out_valid", 0, 64'(if0.out_valid), 64'(0));
    check("midrst_out_valid", 1, 64'(if1.out_valid), 64'(0));
    check("midrst_out_valid", 2, 64'(if2.out_valid), 64'(0));
    for (int t = 0; t < 6; t++) step();

    in_valid = 1'b1;
    a = 32'h0000_1111; b = 32'h0000_2222; cin = 1'b0; sub = 1'b0;
    step();
    in_valid = 1'b0;
    got0 = '0;
    for (int c = 1; c <= 6; c++) begin
      if (if0.out_valid) got0 = {if0.ovf, if0.cout, if0.sum};
      step();
    end
    check("post_rst_sum", 0, 64'(got0), 64'(18'h03333));
    drain();

    for (int i = 0; i < 3; i++) check("q_empty", i, 64'(exp_q[i].size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
